// File: rtl/sync_fifo_if.sv
// Bus bundle between a FIFO producer/consumer (master) and the FIFO itself (slave).
// The bundle carries the write and read request lines, the data buses, and all status flags.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 36
);
   logic                  PUSH;
   logic [DATA_WIDTH-1:0] DIN;
   logic                  POP;
   logic [DATA_WIDTH-1:0] DOUT;
   logic                  Full;
   logic                  Empty;
   logic                  Almost_Full;
   logic                  Almost_Empty;
   logic                  Full_Watermark;
   logic                  Empty_Watermark;
   logic                  Overrun_Error;
   logic                  Underrun_Error;

   modport master (
      output PUSH, DIN, POP,
      input  DOUT, Full, Empty, Almost_Full, Almost_Empty,
             Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
   );

   modport slave (
      input  PUSH, DIN, POP,
      output DOUT, Full, Empty, Almost_Full, Almost_Empty,
             Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, count-decoded status flags,
// programmable watermarks and one-cycle overrun/underrun pulses.
module sync_fifo #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 10,
   parameter int FULL_WM    = (2**ADDR_WIDTH) - 4,
   parameter int EMPTY_WM   = 4
) (
   input  logic       clock0,
   input  logic       Sync_Flush,
   sync_fifo_if.slave fifo
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_DEPTH_M1 = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] LP_ONE      = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] LP_FULL_WM  = (ADDR_WIDTH+1)'(FULL_WM);
   localparam logic [ADDR_WIDTH:0] LP_EMPTY_WM = (ADDR_WIDTH+1)'(EMPTY_WM);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_overrun;
   logic                  r_underrun;

   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;

   // Handshake: a PUSH is taken on an edge only if Full was low before that edge,
   // a POP only if Empty was low; a refused request is dropped and pulses its error flag.
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == LP_DEPTH);
   assign w_push_ok = fifo.PUSH & ~w_full;
   assign w_pop_ok  = fifo.POP & ~w_empty;

   always_ff @(posedge clock0) begin
      if (!Sync_Flush && w_push_ok) begin
         r_mem[r_wptr] <= fifo.DIN;
      end
   end

   always_ff @(posedge clock0) begin
      if (Sync_Flush) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_dout     <= '0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_dout <= r_mem[r_rptr];
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_overrun  <= fifo.PUSH & w_full;
         r_underrun <= fifo.POP & w_empty;
      end
   end

   assign fifo.DOUT            = r_dout;
   assign fifo.Empty           = w_empty;
   assign fifo.Full            = w_full;
   assign fifo.Almost_Empty    = (r_count == LP_ONE);
   assign fifo.Almost_Full     = (r_count == LP_DEPTH_M1);
   assign fifo.Empty_Watermark = (r_count <= LP_EMPTY_WM);
   assign fifo.Full_Watermark  = (r_count >= LP_FULL_WM);
   assign fifo.Overrun_Error   = r_overrun;
   assign fifo.Underrun_Error  = r_underrun;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: hand-written vector table plus fill/drain,
// overrun, underrun, concurrent and mid-operation flush sequences against a queue model.
`timescale 1ns/1ps
module tb_sync_fifo;
   localparam int DW    = 36;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;
   localparam int FWM   = DEPTH - 4;
   localparam int EWM   = 4;

   logic clk;
   logic flush;
   int   n_checks;
   int   n_errors;

   logic [DW-1:0] exp_q[$];
   int            m_count;
   logic [DW-1:0] m_dout;

   sync_fifo_if #(.DATA_WIDTH(DW)) ff_if ();

   sync_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .FULL_WM(FWM),
      .EMPTY_WM(EWM)
   ) dut (
      .clock0(clk),
      .Sync_Flush(flush),
      .fifo(ff_if.slave)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          push;
      logic          pop;
      logic [DW-1:0] din;
      logic [DW-1:0] exp_dout;
      logic          exp_empty;
      logic          exp_ae;
      logic          exp_und;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input logic e_ovr, input logic e_und);
      chk("dout",     64'(ff_if.DOUT),            64'(m_dout));
      chk("empty",    64'(ff_if.Empty),           64'(m_count == 0));
      chk("full",     64'(ff_if.Full),            64'(m_count == DEPTH));
      chk("alm_full", 64'(ff_if.Almost_Full),     64'(m_count == DEPTH - 1));
      chk("alm_empty",64'(ff_if.Almost_Empty),    64'(m_count == 1));
      chk("empty_wm", 64'(ff_if.Empty_Watermark), 64'(m_count <= EWM));
      chk("full_wm",  64'(ff_if.Full_Watermark),  64'(m_count >= FWM));
      chk("overrun",  64'(ff_if.Overrun_Error),   64'(e_ovr));
      chk("underrun", 64'(ff_if.Underrun_Error),  64'(e_und));
   endtask

   // driver: one clock edge with the given requests, then model update and checks
   task automatic step(input logic push, input logic pop, input logic [DW-1:0] din);
      logic push_ok, pop_ok, e_ovr, e_und;
      push_ok = push && (m_count != DEPTH);
      pop_ok  = pop && (m_count != 0);
      e_ovr   = push && (m_count == DEPTH);
      e_und   = pop && (m_count == 0);
      ff_if.PUSH = push;
      ff_if.POP  = pop;
      ff_if.DIN  = din;
      @(posedge clk);
      #1;
      if (pop_ok) m_dout = exp_q.pop_front();
      if (push_ok) exp_q.push_back(din);
      m_count = m_count + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
      check_all(e_ovr, e_und);
   endtask

   task automatic do_flush(input logic push, input logic pop);
      flush      = 1'b1;
      ff_if.PUSH = push;
      ff_if.POP  = pop;
      ff_if.DIN  = 36'hF_FFFF_FFFF;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      ff_if.PUSH = 1'b0;
      ff_if.POP  = 1'b0;
      m_count = 0;
      exp_q.delete();
      m_dout = '0;
      check_all(1'b0, 1'b0);
   endtask

   function automatic logic [DW-1:0] pat(input int i);
      logic [DW-1:0] v;
      v = DW'(i) | (DW'(i) << 20) | DW'(36'h5_5000);
      return v;
   endfunction

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] v;
      v = {4'($urandom_range(15, 0)), 32'($urandom())};
      return v;
   endfunction

   initial begin
      logic saw_bad;
      logic [DW-1:0] x;
      n_checks   = 0;
      n_errors   = 0;
      m_count    = 0;
      m_dout     = '0;
      flush      = 1'b1;
      ff_if.PUSH = 1'b0;
      ff_if.POP  = 1'b0;
      ff_if.DIN  = '0;

      vecs[0] = '{1'b0, 1'b1, 36'h0,           36'h0,           1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 36'h1_1111_1111, 36'h0,           1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 36'h2_2222_2222, 36'h0,           1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 36'h3_3333_3333, 36'h1_1111_1111, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 36'h0,           36'h2_2222_2222, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 36'h0,           36'h3_3333_3333, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 36'h4_4444_4444, 36'h3_3333_3333, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 1'b1, 36'h0,           36'h4_4444_4444, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 36'h0,           36'h4_4444_4444, 1'b1, 1'b0, 1'b0};

      // reset state
      do_flush(1'b0, 1'b0);

      // table vectors, including push+pop while empty (no bypass) and underrun
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].push, vecs[i].pop, vecs[i].din);
         chk("vec_dout",  64'(ff_if.DOUT),           64'(vecs[i].exp_dout));
         chk("vec_empty", 64'(ff_if.Empty),          64'(vecs[i].exp_empty));
         chk("vec_ae",    64'(ff_if.Almost_Empty),   64'(vecs[i].exp_ae));
         chk("vec_und",   64'(ff_if.Underrun_Error), 64'(vecs[i].exp_und));
      end

      // fill to full; watermark and almost-full flags checked every cycle
      do_flush(1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, pat(i));
         if (i == DEPTH - 2) chk("af_at_1023", 64'(ff_if.Almost_Full), 64'd1);
         if (i == DEPTH - 1) chk("full_at_1024", 64'(ff_if.Full), 64'd1);
      end

      // overrun at full, then idle to see the pulse drop
      step(1'b1, 1'b0, 36'h0_000A_BCDE);
      chk("ovr_pulse", 64'(ff_if.Overrun_Error), 64'd1);
      step(1'b0, 1'b0, '0);
      chk("ovr_drop", 64'(ff_if.Overrun_Error), 64'd0);

      // drain
      saw_bad = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, '0);
         if (ff_if.DOUT == 36'h0_000A_BCDE) saw_bad = 1'b1;
      end
      chk("no_overrun_word", 64'(saw_bad), 64'd0);
      chk("empty_at_end", 64'(ff_if.Empty), 64'd1);

      // underrun after flush
      do_flush(1'b0, 1'b0);
      step(1'b0, 1'b1, '0);
      chk("und_dout", 64'(ff_if.DOUT), 64'd0);
      step(1'b0, 1'b0, '0);

      // concurrent push/pop at half-full across several pointer wraps
      for (int i = 0; i < 512; i++) step(1'b1, 1'b0, rnd());
      for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, rnd());
      chk("conc_count", 64'(m_count), 64'd512);
      for (int i = 0; i < 512; i++) step(1'b0, 1'b1, '0);
      chk("conc_empty", 64'(ff_if.Empty), 64'd1);

      // flush at count 300 with push and pop asserted
      for (int i = 0; i < 300; i++) step(1'b1, i[0], rnd());
      for (int i = 0; i < 300 - m_count; i++) step(1'b1, 1'b0, rnd());
      while (m_count < 300) step(1'b1, 1'b0, rnd());
      do_flush(1'b1, 1'b1);
      chk("flush_empty", 64'(ff_if.Empty), 64'd1);
      chk("flush_dout", 64'(ff_if.DOUT), 64'd0);
      x = 36'h9_8765_4321;
      step(1'b1, 1'b0, x);
      step(1'b0, 1'b1, '0);
      chk("post_flush_rt", 64'(ff_if.DOUT), 64'(x));
      step(1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36, width of DIN and DOUT.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10; DEPTH = 2^ADDR_WIDTH entries.
REQ-003 SHALL have parameter FULL_WM, default DEPTH-4; programmable full threshold.
REQ-004 SHALL have parameter EMPTY_WM, default 4; programmable empty threshold.
REQ-005 SHALL have ports clock0 (in, 1, sole clock, rising edge) and Sync_Flush (in, 1); one clock, reset is synchronous and active-high.
REQ-006 SHALL have ports PUSH (in, 1, write request) and DIN (in, DATA_WIDTH, write data).
REQ-007 SHALL have ports POP (in, 1, read request) and DOUT (out, DATA_WIDTH, registered read data).
REQ-008 SHALL have outputs Full, Empty, Almost_Full and Almost_Empty, each 1 bit, as occupancy flags.
REQ-009 SHALL have outputs Full_Watermark and Empty_Watermark, each 1 bit, as programmable threshold flags.
REQ-010 SHALL have outputs Overrun_Error and Underrun_Error, each 1 bit, as single-cycle error pulses.

Function
REQ-011 SHALL keep DEPTH x DATA_WIDTH storage, write pointer, read pointer (ADDR_WIDTH bits each, natural wrap DEPTH-1 -> 0) and occupancy count (ADDR_WIDTH+1 bits, range 0..DEPTH).
REQ-012 SHALL accept a write when PUSH=1 and Full=0 at the rising edge: DIN stored at write pointer, write pointer +1.
REQ-013 SHALL accept a read when POP=1 and Empty=0 at the rising edge: DOUT <= entry at read pointer at that edge (1-cycle latency), read pointer +1.
REQ-014 SHALL hold DOUT unchanged on any edge without an accepted read.
REQ-015 SHALL evaluate acceptance only from flag values registered before the edge; a push while Full SHALL be rejected even if POP is also accepted that cycle.
REQ-016 SHALL, for simultaneous accepted push and pop, leave the count unchanged and advance both pointers.
REQ-017 SHALL, for PUSH=1 and POP=1 while Empty, accept the push, reject the pop and pulse Underrun_Error; the new word SHALL NOT bypass to DOUT.
REQ-018 SHALL change count by +1 on push-only accepted, -1 on pop-only accepted, else 0.
REQ-019 SHALL decode all flags from the count register, so each flag is valid the cycle after the causing edge.
REQ-020 SHALL set the flags from count as follows: Empty = (count==0); Full = (count==DEPTH); Almost_Empty = (count==1); Almost_Full = (count==DEPTH-1); Empty_Watermark = (count<=EMPTY_WM); Full_Watermark = (count>=FULL_WM).
REQ-021 SHALL assert Overrun_Error for exactly the cycle after an edge with PUSH=1 and Full=1; the rejected write SHALL NOT alter storage or pointers.
REQ-022 SHALL assert Underrun_Error for exactly the cycle after an edge with POP=1 and Empty=1; DOUT SHALL be held.
REQ-023 SHALL return words in write order across any number of pointer wraps, with no loss or duplication.

Reset
REQ-024 SHALL, when Sync_Flush=1 at a rising edge, clear both pointers and count, set DOUT=0, Empty=1, Empty_Watermark=1, and all other flags and error outputs to 0.
REQ-025 SHALL give Sync_Flush priority over PUSH/POP in the same cycle: no write is stored, no read occurs and no error pulses.
REQ-026 SHALL leave storage contents unspecified after flush; contents SHALL never be observable before being rewritten.
REQ-027 SHALL, on flush mid-operation (any count), be Empty the cycle after the flush edge and accept a push on the first edge with Sync_Flush=0.

Verification
REQ-028 SHALL cover fill/drain: flush, push 1024 words d[i]=i|(i<<20)|0x55000 (36-bit mask), then pop 1024. Required: Full=1 after push 1024, Almost_Full=1 at count 1023, DOUT=d[i] one cycle after each pop, Empty=1 at end, zero mismatches.
REQ-029 SHALL cover overrun: at count=1024, PUSH=1 with DIN=0xABCDE. Required: Overrun_Error high one cycle, count stays 1024, and a later drain never returns 0xABCDE.
REQ-030 SHALL cover underrun: after flush, POP=1 for one edge. Required: Underrun_Error high one cycle, DOUT=0, Empty stays 1.
REQ-031 SHALL cover concurrent access: at count=512, PUSH=POP=1 for 2000 cycles. Required: count constant 512, order preserved through several pointer wraps.
REQ-032 SHALL cover watermarks: fill 0->1024 then drain 1024->0. Required: Empty_Watermark=1 for count<=4, Full_Watermark=1 for count>=1020, Almost_Empty=1 only at count 1.
REQ-033 SHALL cover mid-operation flush: at count=300, assert Sync_Flush with PUSH=POP=1. Required: next cycle count=0, Empty=1, DOUT=0, no error pulse, and the first subsequent push/pop round-trips correctly.
